// File: rtl/nonce_dispatcher.sv
// Nonce sweep controller for a double-SHA256 header hasher: issues nonce-stamped headers, compares digests to target.
// Optional NONCE_DISPATCH_HASH_CAPTURE_EN adds a found_hash output holding the winning digest.
module nonce_dispatcher #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [639:0]       template,
    input  logic [255:0]       target,
    input  logic [31:0]        nonce_first,
    input  logic [31:0]        nonce_last,
    output logic [639:0]       hdr_out,
    output logic               hdr_valid,
    input  logic               hdr_ready,
    input  logic [255:0]       hash_in,
    input  logic               hash_valid,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [31:0]        found_nonce,
    output logic [CNT_W-1:0]   hash_count,
    output logic               protocol_err
`ifdef NONCE_DISPATCH_HASH_CAPTURE_EN
    ,
    output logic [255:0]       found_hash
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, next_state;
    logic [639:32]   tmpl_q;
    logic [255:0]    target_q;
    logic [31:0]     last_q;
    logic [31:0]     cur_nonce;
    logic            issued_all;
    logic [31:0]     fifo [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [IW-1:0]   inflight;
    logic            issue, ret, hit;
    logic            unused_nonce_slot;

    assign unused_nonce_slot = ^template[31:0];

    assign hdr_out = {tmpl_q, cur_nonce[7:0], cur_nonce[15:8], cur_nonce[23:16], cur_nonce[31:24]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        hdr_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        // inflight is only non-zero in RUN/DRAIN, so any accepted digest is a FIFO pop
        ret        = hash_valid && (inflight != '0);
        hit        = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                hdr_valid = !issued_all && (inflight < IW'(DEPTH));
                hit       = ret && (hash_in <= target_q);
                if (hit || abort)                        next_state = DRAIN;
                else if (issued_all && inflight == '0)   next_state = DONE;
            end
            DRAIN: begin
                busy = 1'b1;
                if (inflight == '0) next_state = found ? DONE : IDLE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        issue = hdr_valid && hdr_ready;
    end

    always_ff @(posedge clk) begin
        if (issue) fifo[wr_ptr] <= cur_nonce;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmpl_q       <= '0;
            target_q     <= '0;
            last_q       <= '0;
            cur_nonce    <= '0;
            issued_all   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= '0;
            found        <= 1'b0;
            found_nonce  <= '0;
            hash_count   <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                tmpl_q       <= template[639:32];
                target_q     <= target;
                last_q       <= nonce_last;
                cur_nonce    <= nonce_first;
                issued_all   <= 1'b0;
                found        <= 1'b0;
                found_nonce  <= '0;
                hash_count   <= '0;
                protocol_err <= 1'b0;
            end
            if (issue) begin
                wr_ptr    <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                cur_nonce <= cur_nonce + 32'd1;
                if (cur_nonce == last_q) issued_all <= 1'b1;
            end
            if (ret) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                if (hash_count != '1) hash_count <= hash_count + 1'b1;
            end
            if (issue && !ret)      inflight <= inflight + 1'b1;
            else if (!issue && ret) inflight <= inflight - 1'b1;
            if (hit) begin
                found       <= 1'b1;
                found_nonce <= fifo[rd_ptr];
            end
            // a stray digest that coincides with start still leaves the error set
            if (hash_valid && inflight == '0) protocol_err <= 1'b1;
        end
    end

`ifdef NONCE_DISPATCH_HASH_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst)                        found_hash <= '0;
        else if (state == IDLE && start) found_hash <= '0;
        else if (hit)                   found_hash <= hash_in;
    end
`endif

endmodule
